// File: rtl/dct_pkg.sv
// dct_pkg: shared constants for the 8-point Chen DCT pipeline (cosine table, K_m derivation, stage count).
// Latency: n/a (elaboration-time constants only).
// Backpressure: n/a.
package dct_pkg;

  localparam int STAGES = 3;

  // cos(m*pi/16) for m = 0..7
  function automatic real cos_tab(input int m);
    case (m)
      0:       return 1.0;
      1:       return 0.9807852804032304;
      2:       return 0.9238795325112867;
      3:       return 0.8314696123025452;
      4:       return 0.7071067811865476;
      5:       return 0.5555702330196022;
      6:       return 0.3826834323650898;
      7:       return 0.1950903220161283;
      default: return 0.0;
    endcase
  endfunction

  // K_m = round(2^frac * cos(m*pi/16) / 2), clamped into a signed const_w-bit range
  function automatic int k_const(input int m, input int frac, input int const_w);
    real v;
    int  r;
    int  lim;
    v   = real'(1 << frac) * cos_tab(m) / 2.0;
    r   = $rtoi(v + 0.5);
    lim = (1 << (const_w - 1)) - 1;
    if (r > lim) r = lim;
    return r;
  endfunction

endpackage

// File: rtl/dct_round_sat.sv
// dct_round_sat: round-half-up by 2^FRAC then clamp (DCT8_CHEN_PIPE_SAT_EN) or wrap to OUT_W bits.
// Latency: combinational.
// Backpressure: none; the enclosing stage register owns flow control.
module dct_round_sat #(
  parameter int ACC_W = 31,
  parameter int OUT_W = 16,
  parameter int FRAC  = 8
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [OUT_W-1:0] res
);

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1 << (FRAC - 1));

`ifdef DCT8_CHEN_PIPE_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] rnd;

  always_comb begin
    rnd = (acc + HALF) >>> FRAC;
    if (rnd > MAX_V)      res = MAX_V[OUT_W-1:0];
    else if (rnd < MIN_V) res = MIN_V[OUT_W-1:0];
    else                  res = rnd[OUT_W-1:0];
  end
`else
  assign res = OUT_W'((acc + HALF) >>> FRAC);
`endif

endmodule

// File: rtl/dct8_chen_pipe.sv
// dct8_chen_pipe: orthonormal 8-point DCT-II, Chen factorisation; DCT8_CHEN_PIPE_SAT_EN selects clamp over wrap.
// Latency: 3 cycles from accept to out_valid, 1 vector/cycle throughput.
// Backpressure: whole pipe freezes while out_valid && !out_ready; in_ready is that advance term.
module dct8_chen_pipe
  import dct_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 16,
  parameter int CONST_W = 12,
  parameter int FRAC    = 8,
  parameter int USER_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0][IN_W-1:0]  in_data,
  input  logic [USER_W-1:0]     in_user,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0][OUT_W-1:0] out_data,
  output logic [USER_W-1:0]     out_user
);

  localparam int ACC_W = IN_W + CONST_W + 3;

  localparam logic signed [CONST_W-1:0] K1 = CONST_W'(k_const(1, FRAC, CONST_W));
  localparam logic signed [CONST_W-1:0] K2 = CONST_W'(k_const(2, FRAC, CONST_W));
  localparam logic signed [CONST_W-1:0] K3 = CONST_W'(k_const(3, FRAC, CONST_W));
  localparam logic signed [CONST_W-1:0] K4 = CONST_W'(k_const(4, FRAC, CONST_W));
  localparam logic signed [CONST_W-1:0] K5 = CONST_W'(k_const(5, FRAC, CONST_W));
  localparam logic signed [CONST_W-1:0] K6 = CONST_W'(k_const(6, FRAC, CONST_W));
  localparam logic signed [CONST_W-1:0] K7 = CONST_W'(k_const(7, FRAC, CONST_W));

  logic [STAGES-1:0]       vld;
  logic                    advance;
  logic signed [IN_W:0]    a [4];
  logic signed [IN_W:0]    b [4];
  logic [USER_W-1:0]       user1;
  logic [USER_W-1:0]       user2;
  logic signed [ACC_W-1:0] e0, e1, d0, d1;
  logic signed [ACC_W-1:0] bw   [4];
  logic signed [ACC_W-1:0] p_nx [8][4];
  logic signed [ACC_W-1:0] p    [8][4];
  logic signed [ACC_W-1:0] acc  [8];
  logic [OUT_W-1:0]        res  [8];

  function automatic logic signed [ACC_W-1:0] mul(input logic signed [ACC_W-1:0] v,
                                                  input logic signed [CONST_W-1:0] k);
    return v * ACC_W'(k);
  endfunction

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          vld <= '0;
    else if (advance) vld <= {vld[STAGES-2:0], in_valid};
  end

  // S1: butterflies
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        a[n] <= '0;
        b[n] <= '0;
      end
      user1 <= '0;
    end else if (advance && in_valid) begin
      for (int n = 0; n < 4; n++) begin
        a[n] <= (IN_W+1)'($signed(in_data[n])) + (IN_W+1)'($signed(in_data[7-n]));
        b[n] <= (IN_W+1)'($signed(in_data[n])) - (IN_W+1)'($signed(in_data[7-n]));
      end
      user1 <= in_user;
    end
  end

  // S2: even half uses the second butterfly level, odd half multiplies b directly
  always_comb begin
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 4; j++)
        p_nx[k][j] = '0;
    e0 = ACC_W'(a[0]) + ACC_W'(a[3]);
    e1 = ACC_W'(a[1]) + ACC_W'(a[2]);
    d0 = ACC_W'(a[0]) - ACC_W'(a[3]);
    d1 = ACC_W'(a[1]) - ACC_W'(a[2]);
    for (int i = 0; i < 4; i++) bw[i] = ACC_W'(b[i]);

    p_nx[0][0] =  mul(e0, K4);    p_nx[0][1] =  mul(e1, K4);
    p_nx[4][0] =  mul(e0, K4);    p_nx[4][1] = -mul(e1, K4);
    p_nx[2][0] =  mul(d0, K2);    p_nx[2][1] =  mul(d1, K6);
    p_nx[6][0] =  mul(d0, K6);    p_nx[6][1] = -mul(d1, K2);

    p_nx[1][0] =  mul(bw[0], K1); p_nx[1][1] =  mul(bw[1], K3);
    p_nx[1][2] =  mul(bw[2], K5); p_nx[1][3] =  mul(bw[3], K7);
    p_nx[3][0] =  mul(bw[0], K3); p_nx[3][1] = -mul(bw[1], K7);
    p_nx[3][2] = -mul(bw[2], K1); p_nx[3][3] = -mul(bw[3], K5);
    p_nx[5][0] =  mul(bw[0], K5); p_nx[5][1] = -mul(bw[1], K1);
    p_nx[5][2] =  mul(bw[2], K7); p_nx[5][3] =  mul(bw[3], K3);
    p_nx[7][0] =  mul(bw[0], K7); p_nx[7][1] = -mul(bw[1], K5);
    p_nx[7][2] =  mul(bw[2], K3); p_nx[7][3] = -mul(bw[3], K1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++)
        for (int j = 0; j < 4; j++)
          p[k][j] <= '0;
      user2 <= '0;
    end else if (advance && vld[0]) begin
      p     <= p_nx;
      user2 <= user1;
    end
  end

  // S3: accumulate, round, width-convert
  always_comb begin
    for (int k = 0; k < 8; k++) acc[k] = p[k][0] + p[k][1] + p[k][2] + p[k][3];
  end

  for (genvar k = 0; k < 8; k++) begin : g_rs
    dct_round_sat #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .FRAC  (FRAC)
    ) u_rs (
      .acc (acc[k]),
      .res (res[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_user <= '0;
    end else if (advance && vld[1]) begin
      for (int k = 0; k < 8; k++) out_data[k] <= res[k];
      out_user <= user2;
    end
  end

endmodule

// File: tb/tb_dct8_chen_pipe.sv
// tb_dct8_chen_pipe: directed and random stimulus against a matrix-form DCT reference with a scoreboard.
// A second 12-bit instance exercises the saturate/wrap boundary.
module tb_dct8_chen_pipe;

  typedef struct packed {
    logic [7:0][15:0] d;
    logic [7:0]       u;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid, in_ready, out_valid, out_ready;
  logic [7:0][15:0] in_data, out_data;
  logic [7:0]       in_user, out_user;

  logic             s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [7:0][11:0] s_in_data, s_out_data;
  logic [7:0]       s_in_user, s_out_user;

  exp_t exp_q [$];
  int   seen_tags [$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   imp_exp [8] = '{91, 126, 118, 106, 91, 71, 49, 25};

  dct8_chen_pipe u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_user   (in_user),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_user  (out_user)
  );

  dct8_chen_pipe #(.IN_W(12), .OUT_W(12)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .in_user   (s_in_user),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .out_user  (s_out_user)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Direct matrix form: coefficient of x[n] in X[k] is cos((2n+1)k*pi/16)/2 in FRAC=8 fixed point
  function automatic exp_t model(input logic [7:0][15:0] x, input logic [7:0] u);
    int     kt [8] = '{0, 126, 118, 106, 91, 71, 49, 25};
    exp_t   e;
    longint s, r;
    int     ang, m, sgn;
    for (int k = 0; k < 8; k++) begin
      s = 0;
      for (int n = 0; n < 8; n++) begin
        if (k == 0) begin
          m = 4; sgn = 1;
        end else begin
          ang = ((2 * n + 1) * k) % 32;
          if (ang < 8)       begin m = ang;      sgn = 1;  end
          else if (ang < 16) begin m = 16 - ang; sgn = -1; end
          else if (ang < 24) begin m = ang - 16; sgn = -1; end
          else               begin m = 32 - ang; sgn = 1;  end
        end
        s = s + longint'($signed(x[n])) * sgn * kt[m];
      end
      r = (s + 128) >>> 8;
`ifdef DCT8_CHEN_PIPE_SAT_EN
      if (r > 32767)       r = 32767;
      else if (r < -32768) r = -32768;
`endif
      e.d[k] = r[15:0];
    end
    e.u = u;
    return e;
  endfunction

  always @(negedge clk) begin : scoreboard
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        seen_tags.push_back(int'(out_user));
        check("queue_has_entry_at_output", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          for (int k = 0; k < 8; k++)
            check($sformatf("X%0d", k), $signed(out_data[k]), $signed(e.d[k]));
          check("out_user", out_user, e.u);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data, in_user));
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after the accepting edge; returns cycles until out_valid (bounded)
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic send_one(input logic [7:0][15:0] d, input logic [7:0] u);
    in_data  = d;
    in_user  = u;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin : stim
    int lat, t, sent, cyc, base;
    bit fire;
    logic [7:0][15:0] v;

    in_valid = 0; in_data = '0; in_user = '0; out_ready = 1;
    s_in_valid = 0; s_in_data = '0; s_in_user = '0; s_out_ready = 1;
    #1 rst = 1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_user", out_user, 0);
    for (int k = 0; k < 8; k++) check($sformatf("rst_X%0d", k), out_data[k], 0);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("post_rst_in_ready", in_ready, 1);

    // DC
    send_one({8{16'd100}}, 8'h11);
    wait_out(lat);
    check("dc_latency", lat, 3);
    check("dc_X0", $signed(out_data[0]), 284);
    for (int k = 1; k < 8; k++) check($sformatf("dc_X%0d", k), $signed(out_data[k]), 0);
    tick();

    // impulse
    v = '0;
    v[0] = 16'd256;
    send_one(v, 8'h22);
    wait_out(lat);
    check("imp_latency", lat, 3);
    for (int k = 0; k < 8; k++) check($sformatf("imp_X%0d", k), $signed(out_data[k]), imp_exp[k]);
    tick();

    // back-to-back with a 5-cycle output stall mid-stream
    base = seen_tags.size();
    sent = 0; cyc = 0;
    while (sent < 10 && cyc < 200) begin
      in_valid = 1;
      in_user  = 8'(sent);
      for (int k = 0; k < 8; k++) in_data[k] = 16'($urandom);
      out_ready = !(cyc >= 4 && cyc < 9);
      #1;
      fire = in_valid && in_ready;
      tick();
      if (fire) sent++;
      cyc++;
    end
    in_valid = 0; out_ready = 1;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin tick(); t++; end
    check("stall_drained", exp_q.size(), 0);
    check("stall_count", seen_tags.size() - base, 10);
    for (int i = 0; i < 10; i++)
      if (base + i < seen_tags.size()) check("stall_tag_order", seen_tags[base + i], i);
    tick();

    // reset with three vectors in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      in_user  = 8'(48 + i);
      for (int k = 0; k < 8; k++) in_data[k] = 16'($urandom);
      tick();
    end
    in_valid = 0;
    check("pre_rst_out_valid", out_valid, 1);
    #1 rst = 1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_user", out_user, 0);
    check("mid_rst_X0", out_data[0], 0);
    tick();
    rst = 0;
    for (int k = 0; k < 8; k++) v[k] = 16'($urandom);
    send_one(v, 8'hA5);
    wait_out(lat);
    check("post_rst_latency", lat, 3);
    check("post_rst_tag", out_user, 8'hA5);
    tick();
    check("post_rst_single", out_valid, 0);

    // saturation / wrap boundary on the 12-bit instance
    s_in_data = {8{12'h7FF}}; s_in_user = 8'h01; s_in_valid = 1;
    tick();
    s_in_valid = 0;
    t = 1;
    while (!s_out_valid && t < 20) begin tick(); t++; end
    check("sat_pos_latency", t, 3);
`ifdef DCT8_CHEN_PIPE_SAT_EN
    check("sat_pos_X0", $signed(s_out_data[0]), 2047);
`else
    check("sat_pos_X0", $signed(s_out_data[0]), 1725);
`endif
    check("sat_pos_X1", $signed(s_out_data[1]), 0);
    tick();
    s_in_data = {8{12'h800}}; s_in_user = 8'h02; s_in_valid = 1;
    tick();
    s_in_valid = 0;
    t = 1;
    while (!s_out_valid && t < 20) begin tick(); t++; end
`ifdef DCT8_CHEN_PIPE_SAT_EN
    check("sat_neg_X0", $signed(s_out_data[0]), -2048);
`else
    check("sat_neg_X0", $signed(s_out_data[0]), -1728);
`endif
    check("sat_neg_tag", s_out_user, 8'h02);
    tick();

    // random traffic with random backpressure
    t = 0; sent = 0;
    while (sent < 300 && t < 4000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 8; k++) begin
        case ($urandom_range(0, 7))
          0:       in_data[k] = 16'h7FFF;
          1:       in_data[k] = 16'h8000;
          default: in_data[k] = 16'($urandom);
        endcase
      end
      in_user   = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      fire = in_valid && in_ready;
      tick();
      if (fire) sent++;
      t++;
    end
    in_valid = 0; out_ready = 1;
    check("rand_sent", sent, 300);
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin tick(); t++; end
    check("rand_drained", exp_q.size(), 0);
    tick();
    check("final_idle", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dct8_chen_pipe.md
DCT8_CHEN_PIPE -- requirements
Module: dct8_chen_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 16: signed input sample width.
REQ-002 SHALL have parameter OUT_W, default 16: signed output coefficient width.
REQ-003 SHALL have parameter CONST_W, default 12: signed coefficient constant width.
REQ-004 SHALL have parameter FRAC, default 8: fractional bits of constants; legal range 1 to CONST_W-2.
REQ-005 SHALL have parameter USER_W, default 8: sideband tag width.
REQ-006 SHALL have ports `clk in 1`: single clock, with all state on its rising edge.
REQ-007 SHALL have port `rst in 1`: asynchronous, active-high reset.
REQ-008 SHALL have ports `in_valid in 1` and `in_ready out 1`: input handshake.
REQ-009 SHALL have port `in_data in 8 x IN_W`: samples x0..x7, two's complement.
REQ-010 SHALL have port `in_user in USER_W`: tag carried with the vector.
REQ-011 SHALL have ports `out_valid out 1` and `out_ready in 1`: output handshake.
REQ-012 SHALL have port `out_data out 8 x OUT_W`: coefficients X0..X7.
REQ-013 SHALL have port `out_user out USER_W`: tag of the vector on out_data.

Function
REQ-014 SHALL compute the orthonormal 8-point DCT-II, X[k] = (C(k)/2)·Σ x[n]·cos((2n+1)kπ/16), where C(0)=1/√2 and C(k>0)=1.
REQ-015 SHALL use constants K_m = round(2^FRAC·cos(mπ/16)/2) for m=1..7, quantised to CONST_W signed bits.
REQ-016 SHALL implement three pipeline stages.
- S1: butterflies, a_n = x_n + x_(7-n) and b_n = x_n − x_(7-n).
- S2: Chen even/odd constant multiplies.
- S3: accumulate, round, width-convert.
REQ-017 SHALL size internal accumulators IN_W+CONST_W+3 bits so that no intermediate overflows.
REQ-018 SHALL round by adding 2^(FRAC-1) and then arithmetic-shifting right by FRAC (round half toward +∞).
REQ-019 SHALL accept a vector only on a cycle where in_valid && in_ready.
REQ-020 SHALL present the result on out_valid exactly 3 cycles after acceptance when out_ready stays high; throughput SHALL be 1 vector/cycle.
REQ-021 SHALL stall the whole pipeline when advance = !out_valid || out_ready is low; in_ready SHALL equal advance, combinationally.
REQ-022 SHALL hold out_data and out_user stable while out_valid && !out_ready, with no vector lost or duplicated.
REQ-023 SHALL move each stage's valid bit with its data, so that bubbles propagate and partially filled pipelines drain correctly.
REQ-024 SHALL deliver out_user with the same vector it entered with.

Reset
REQ-025 SHALL, on assertion of rst, immediately clear every stage valid bit and drive out_valid=0, out_data=0 and out_user=0.
REQ-026 SHALL discard in-flight vectors when rst is asserted mid-operation; the first output after reset SHALL be the first vector accepted after reset.
REQ-027 SHALL drive in_ready=1 during and after reset, since the pipeline is empty.

Configuration
REQ-028 SHALL, with `DCT8_CHEN_PIPE_SAT_EN` defined, clamp each rounded result to [−2^(OUT_W-1), 2^(OUT_W-1)−1].
REQ-029 SHALL, without `DCT8_CHEN_PIPE_SAT_EN`, truncate each rounded result to its low OUT_W bits (wrap-around).

Structure
REQ-030 SHALL place in package dct_pkg:
- the real-valued cosine table;
- the function that derives K_m from FRAC and CONST_W;
- the stage-count constant (3).
REQ-031 SHALL place rounding and saturate/wrap in sub-module dct_round_sat (params ACC_W, OUT_W, FRAC), instantiated 8 times in S3.

Verification (IN_W=16, OUT_W=16, CONST_W=12, FRAC=8 unless stated)
REQ-032 SHALL cover DC input: x0..x7 = 100 -> X0=284 and X1..X7=0, three cycles later.
REQ-033 SHALL cover impulse input: x0=256, others 0 -> X = [91,126,118,106,91,71,49,25].
REQ-034 SHALL cover saturation: IN_W=12, OUT_W=12, all inputs 2047 -> X0=2047 with the macro defined, X0=1725 without it.
REQ-035 SHALL cover back-to-back input with out_ready low for 5 cycles mid-stream.
- No loss, no duplication, order preserved.
- out_user tags 0..9 emerge in sequence.
REQ-036 SHALL cover reset asserted with 3 vectors in flight.
- out_valid falls in the same cycle as rst rises.
- The next vector after reset emerges alone, 3 cycles after it is accepted.
